// File: rtl/invader_bomb.sv
// Invader bomb pool: three falling bombs with spawn cooldown, shield/player/floor retirement.
// Define BOMB_LFSR_JITTER_EN to add an 8-bit LFSR jitter (0..15 frames) to the spawn cooldown.
module invader_bomb #(
    parameter int BOMB_STEP     = 2,
    parameter int FIRE_INTERVAL = 32,
    parameter int FLOOR_Y       = 464,
    parameter int PLAYER_Y      = 440,
    parameter int SPRITE_W      = 32,
    parameter int SPRITE_H      = 32,
    parameter int BOMB_W        = 4,
    parameter int BOMB_H        = 12,
    parameter int PLAYER_H      = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame,
    input  logic        clear,
    input  logic        spawn_valid,
    input  logic [9:0]  spawn_x,
    input  logic [9:0]  spawn_y,
    output logic        spawn_ready,
    input  logic [9:0]  player_x,
    input  logic [2:0]  shield_hit,
    output logic [2:0]  bomb_active,
    output logic [29:0] bomb_x,
    output logic [29:0] bomb_y,
    output logic        player_hit
);

    localparam int SLOTS = 3;

    localparam logic [10:0] BOMB_W_L   = 11'(BOMB_W);
    localparam logic [10:0] BOMB_H_L   = 11'(BOMB_H);
    localparam logic [10:0] SPRITE_W_L = 11'(SPRITE_W);
    localparam logic [10:0] PLAYER_Y_L = 11'(PLAYER_Y);
    localparam logic [10:0] PLAYER_B_L = 11'(PLAYER_Y + PLAYER_H);
    localparam logic [10:0] FLOOR_Y_L  = 11'(FLOOR_Y);
    localparam logic [10:0] STEP_L     = 11'(BOMB_STEP);

    logic [2:0]  active;
    logic [9:0]  pos_x [SLOTS];
    logic [9:0]  pos_y [SLOTS];
    logic [7:0]  cooldown;
    logic [7:0]  reload;
    logic [2:0]  spawn_sel;
    logic        spawn_fire;
    logic [9:0]  new_x;
    logic [9:0]  new_y;
    logic [2:0]  overlap;
    logic [2:0]  floor_hit;
    logic [2:0]  player_strike;

`ifdef BOMB_LFSR_JITTER_EN
    logic [7:0] lfsr;
    logic       lfsr_fb;

    // Fibonacci form of x^8+x^6+x^5+x^4+1, stepped once per frame.
    assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= 8'hA5;
        end else if (frame) begin
            lfsr <= {lfsr[6:0], lfsr_fb};
        end
    end

    assign reload = 8'(FIRE_INTERVAL) + {4'd0, lfsr[3:0]};
`else
    assign reload = 8'(FIRE_INTERVAL);
`endif

    // Lowest-index free slot, derived only from registered state.
    always_comb begin
        spawn_sel = 3'b000;
        if (!active[0]) begin
            spawn_sel = 3'b001;
        end else if (!active[1]) begin
            spawn_sel = 3'b010;
        end else if (!active[2]) begin
            spawn_sel = 3'b100;
        end
    end

    assign spawn_ready = (cooldown == 8'd0) && (spawn_sel != 3'b000) && !clear;
    assign spawn_fire  = spawn_valid && spawn_ready;
    assign new_x       = spawn_x + 10'(SPRITE_W / 2) - 10'(BOMB_W / 2);
    assign new_y       = spawn_y + 10'(SPRITE_H);

    // Widened to 11 bits so edges near 1023 compare without wrapping.
    always_comb begin
        overlap   = 3'b000;
        floor_hit = 3'b000;
        for (int i = 0; i < SLOTS; i++) begin
            overlap[i] = (({1'b0, pos_x[i]} + BOMB_W_L) > {1'b0, player_x})
                      && ({1'b0, pos_x[i]} < ({1'b0, player_x} + SPRITE_W_L))
                      && (({1'b0, pos_y[i]} + BOMB_H_L) > PLAYER_Y_L)
                      && ({1'b0, pos_y[i]} < PLAYER_B_L);
            floor_hit[i] = ({1'b0, pos_y[i]} + STEP_L) >= FLOOR_Y_L;
        end
    end

    assign player_strike = active & ~shield_hit & overlap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cooldown <= 8'd0;
        end else if (clear) begin
            cooldown <= 8'd0;
        end else if (spawn_fire) begin
            cooldown <= reload;
        end else if (frame && cooldown != 8'd0) begin
            cooldown <= cooldown - 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            player_hit <= 1'b0;
        end else if (clear) begin
            player_hit <= 1'b0;
        end else begin
            player_hit <= frame && (player_strike != 3'b000);
        end
    end

    // Shield beats player beats floor; a freshly spawned slot is inactive so it never moves this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active <= 3'b000;
            for (int i = 0; i < SLOTS; i++) begin
                pos_x[i] <= 10'd0;
                pos_y[i] <= 10'd0;
            end
        end else if (clear) begin
            active <= 3'b000;
        end else begin
            for (int i = 0; i < SLOTS; i++) begin
                if (spawn_fire && spawn_sel[i]) begin
                    active[i] <= 1'b1;
                    pos_x[i]  <= new_x;
                    pos_y[i]  <= new_y;
                end else if (frame && active[i]) begin
                    if (shield_hit[i] || overlap[i] || floor_hit[i]) begin
                        active[i] <= 1'b0;
                    end else begin
                        pos_y[i] <= pos_y[i] + 10'(BOMB_STEP);
                    end
                end
            end
        end
    end

    assign bomb_active = active;
    assign bomb_x      = {pos_x[2], pos_x[1], pos_x[0]};
    assign bomb_y      = {pos_y[2], pos_y[1], pos_y[0]};

endmodule

// File: tb/tb_invader_bomb.sv
// Directed bench for invader_bomb in its default build (no cooldown jitter).
module tb_invader_bomb;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame = 1'b0;
    logic        clear = 1'b0;
    logic        spawn_valid = 1'b0;
    logic [9:0]  spawn_x = 10'd0;
    logic [9:0]  spawn_y = 10'd0;
    logic        spawn_ready;
    logic [9:0]  player_x = 10'd700;
    logic [2:0]  shield_hit = 3'b000;
    logic [2:0]  bomb_active;
    logic [29:0] bomb_x;
    logic [29:0] bomb_y;
    logic        player_hit;

    int checks = 0;
    int passed = 0;

    invader_bomb dut (
        .clk         (clk),
        .rst         (rst),
        .frame       (frame),
        .clear       (clear),
        .spawn_valid (spawn_valid),
        .spawn_x     (spawn_x),
        .spawn_y     (spawn_y),
        .spawn_ready (spawn_ready),
        .player_x    (player_x),
        .shield_hit  (shield_hit),
        .bomb_active (bomb_active),
        .bomb_x      (bomb_x),
        .bomb_y      (bomb_y),
        .player_hit  (player_hit)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One clock with the given controls, then back to idle.
    task automatic applyStimulus(input logic sv, input logic fr, input logic clr, input logic [2:0] sh);
        spawn_valid = sv;
        frame       = fr;
        clear       = clr;
        shield_hit  = sh;
        step();
        spawn_valid = 1'b0;
        frame       = 1'b0;
        clear       = 1'b0;
        shield_hit  = 3'b000;
    endtask

    task automatic runFrames(input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 3'b000);
        end
    endtask

    task automatic resetDut();
        spawn_valid = 1'b0;
        frame       = 1'b0;
        clear       = 1'b0;
        shield_hit  = 3'b000;
        rst         = 1'b1;
        step();
        rst = 1'b0;
        #1;
    endtask

    function automatic logic [9:0] slotX(input int i);
        return bomb_x[10*i +: 10];
    endfunction

    function automatic logic [9:0] slotY(input int i);
        return bomb_y[10*i +: 10];
    endfunction

    initial begin
        // Asynchronous reset observed between edges.
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_active", 32'(bomb_active), 32'd0);
        checkOutput("rst_x", 32'(bomb_x), 32'd0);
        checkOutput("rst_y", 32'(bomb_y), 32'd0);
        checkOutput("rst_hit", 32'(player_hit), 32'd0);
        step();
        rst = 1'b0;
        #1;
        checkOutput("rst_ready", 32'(spawn_ready), 32'd1);

        // First spawn lands centred under the invader.
        spawn_x = 10'd100;
        spawn_y = 10'd50;
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000);
        checkOutput("spawn_active", 32'(bomb_active), 32'd1);
        checkOutput("spawn_x", 32'(slotX(0)), 32'd114);
        checkOutput("spawn_y", 32'(slotY(0)), 32'd82);
        checkOutput("spawn_ready_low", 32'(spawn_ready), 32'd0);

        // Floor retirement: 450 -> 462 after six frames, gone on the seventh.
        resetDut();
        spawn_y = 10'd418;
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000);
        checkOutput("floor_start_y", 32'(slotY(0)), 32'd450);
        runFrames(6);
        checkOutput("floor_y6", 32'(slotY(0)), 32'd462);
        checkOutput("floor_active6", 32'(bomb_active), 32'd1);
        runFrames(1);
        checkOutput("floor_active7", 32'(bomb_active), 32'd0);
        checkOutput("floor_hold_y", 32'(slotY(0)), 32'd462);
        checkOutput("floor_cool_ready", 32'(spawn_ready), 32'd0);

        // Right edge exactly touching the player is not a hit.
        resetDut();
        player_x = 10'd190;
        spawn_x  = 10'd172;
        spawn_y  = 10'd398;
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000);
        runFrames(1);
        checkOutput("touch_active", 32'(bomb_active), 32'd1);
        checkOutput("touch_y", 32'(slotY(0)), 32'd432);
        checkOutput("touch_hit", 32'(player_hit), 32'd0);

        // Bomb at (200,430) over a player at 190.
        resetDut();
        spawn_x = 10'd186;
        spawn_y = 10'd398;
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000);
        checkOutput("hit_pre", 32'(player_hit), 32'd0);
        runFrames(1);
        checkOutput("hit_active", 32'(bomb_active), 32'd0);
        checkOutput("hit_flag", 32'(player_hit), 32'd1);
        checkOutput("hit_hold_y", 32'(slotY(0)), 32'd430);
        step();
        checkOutput("hit_pulse_end", 32'(player_hit), 32'd0);

        // Fill all three slots; the second spawn shares its cycle with a frame.
        resetDut();
        player_x = 10'd700;
        spawn_x  = 10'd100;
        spawn_y  = 10'd0;
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000);
        runFrames(31);
        checkOutput("cool31_ready", 32'(spawn_ready), 32'd0);
        runFrames(1);
        checkOutput("cool32_ready", 32'(spawn_ready), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b000);
        checkOutput("sf_active", 32'(bomb_active), 32'd3);
        checkOutput("sf_y0", 32'(slotY(0)), 32'd98);
        checkOutput("sf_y1", 32'(slotY(1)), 32'd32);
        runFrames(31);
        checkOutput("sf_cool31_ready", 32'(spawn_ready), 32'd0);
        runFrames(1);
        checkOutput("sf_cool32_ready", 32'(spawn_ready), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000);
        runFrames(32);
        checkOutput("full_active", 32'(bomb_active), 32'd7);
        checkOutput("full_ready", 32'(spawn_ready), 32'd0);
        checkOutput("full_y", 32'(bomb_y), {2'b00, 10'd96, 10'd160, 10'd226});
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000);
        checkOutput("full_ignored_y", 32'(bomb_y), {2'b00, 10'd96, 10'd160, 10'd226});
        spawn_x = 10'd300;
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b001);
        checkOutput("shield_active", 32'(bomb_active), 32'd6);
        checkOutput("shield_ready", 32'(spawn_ready), 32'd1);
        checkOutput("shield_hold_y0", 32'(slotY(0)), 32'd226);
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000);
        checkOutput("refill_active", 32'(bomb_active), 32'd7);
        checkOutput("refill_x0", 32'(slotX(0)), 32'd314);
        checkOutput("refill_y0", 32'(slotY(0)), 32'd32);

        // Shield beats player overlap on the same slot and frame.
        resetDut();
        player_x = 10'd190;
        spawn_x  = 10'd600;
        spawn_y  = 10'd0;
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000);
        runFrames(32);
        spawn_x = 10'd186;
        spawn_y = 10'd398;
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000);
        checkOutput("sp_active", 32'(bomb_active), 32'd3);
        applyStimulus(1'b0, 1'b1, 1'b0, 3'b010);
        checkOutput("sp_after", 32'(bomb_active), 32'd1);
        checkOutput("sp_hit", 32'(player_hit), 32'd0);
        step();
        checkOutput("sp_hit_next", 32'(player_hit), 32'd0);

        // Clear overrides a simultaneous spawn and frame.
        spawn_valid = 1'b1;
        frame       = 1'b1;
        clear       = 1'b1;
        #1;
        checkOutput("clr_ready_comb", 32'(spawn_ready), 32'd0);
        step();
        spawn_valid = 1'b0;
        frame       = 1'b0;
        clear       = 1'b0;
        #1;
        checkOutput("clr_active", 32'(bomb_active), 32'd0);
        checkOutput("clr_ready", 32'(spawn_ready), 32'd1);
        checkOutput("clr_hit", 32'(player_hit), 32'd0);

        // Reset mid-flight discards bombs immediately.
        spawn_x = 10'd100;
        spawn_y = 10'd50;
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000);
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst_active", 32'(bomb_active), 32'd0);
        checkOutput("midrst_x", 32'(bomb_x), 32'd0);
        step();
        rst = 1'b0;
        #1;
        checkOutput("midrst_ready", 32'(spawn_ready), 32'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/invader_bomb.md
INVADER_BOMB -- requirements
Module: invader_bomb

Interface
REQ-001 SHALL have parameter BOMB_STEP, 2, pixels a bomb descends per frame.
REQ-002 SHALL have parameter FIRE_INTERVAL, 32, frames of cooldown loaded on each accepted spawn.
REQ-003 SHALL have parameter FLOOR_Y, 464, y at or beyond which a bomb retires.
REQ-004 SHALL have parameter PLAYER_Y, 440, fixed top row of player sprite.
REQ-005 SHALL have parameter SPRITE_W, 32, invader and player scaled width; SPRITE_H, 32, invader scaled height.
REQ-006 SHALL have parameter BOMB_W, 4, and BOMB_H, 12, scaled bomb size; PLAYER_H, 16.
REQ-007 SHALL have port clk  in  1  clock.
REQ-008 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-009 SHALL have ports frame  in  1  one-cycle frame tick; clear  in  1  synchronous flush of all bombs.
REQ-010 SHALL have ports spawn_valid  in  1; spawn_x, spawn_y  in  10 each  firing invader top-left; spawn_ready  out  1.
REQ-011 SHALL have ports player_x  in  10  player left edge; shield_hit  in  3  per-slot shield collision.
REQ-012 SHALL have ports bomb_active  out  3; bomb_x, bomb_y  out  30 each, slot i at bits [10i+9:10i]; player_hit  out  1.

Function
REQ-013 SHALL manage 3 independent bomb slots, each with active flag, 10-bit x, 10-bit y.
REQ-014 spawn_ready SHALL be combinational: cooldown==0 AND any slot inactive AND clear low, from registered state only.
REQ-015 On clk edge with spawn_valid && spawn_ready, SHALL fill lowest-index inactive slot: x = spawn_x + SPRITE_W/2 - BOMB_W/2, y = spawn_y + SPRITE_H; load cooldown with reload value.
REQ-016 spawn_valid without spawn_ready SHALL be ignored with no state change; requester holds or drops at will.
REQ-017 On frame, cooldown SHALL decrement if nonzero (8-bit, saturating at 0).
REQ-018 On frame, each active slot SHALL be evaluated in priority: shield_hit[i] -> deactivate; else player overlap -> deactivate and flag hit; else y + BOMB_STEP >= FLOOR_Y -> deactivate; else y += BOMB_STEP.
REQ-019 Player overlap SHALL be x+BOMB_W > player_x AND x < player_x+SPRITE_W AND y+BOMB_H > PLAYER_Y AND y < PLAYER_Y+PLAYER_H, in 11-bit unsigned arithmetic (no wrap).
REQ-020 player_hit SHALL be registered, high exactly one clk cycle after any frame with ≥1 player overlap, regardless of how many slots hit.
REQ-021 Spawn and frame in same cycle: spawned slot SHALL not move that cycle; other slots process normally; cooldown loads reload (no decrement).
REQ-022 A slot retiring on a frame SHALL not be spawnable until the following cycle.
REQ-023 clear SHALL deactivate all slots and zero cooldown next edge, overriding spawn and frame; player_hit low.
REQ-024 bomb_x/bomb_y of inactive slots SHALL hold their last value.

Reset
REQ-025 rst SHALL asynchronously set bomb_active=0, bomb_x=0, bomb_y=0, cooldown=0, player_hit=0, LFSR=8'hA5.
REQ-026 rst mid-flight SHALL discard all bombs; spawn_ready high the first cycle after deassertion.

Configuration
REQ-027 Macro BOMB_LFSR_JITTER_EN defined: 8-bit LFSR (x^8+x^6+x^5+x^4+1) advances each frame; reload = FIRE_INTERVAL + lfsr[3:0].
REQ-028 Macro undefined: no LFSR; reload = FIRE_INTERVAL exactly.

Verification
REQ-029 Reset, spawn_valid=1, spawn_x=100, spawn_y=50 -> slot0 active, x=114, y=82, spawn_ready low next cycle.
REQ-030 Slot at y=450, 7 frames, no hits -> y=462 after 6 frames, inactive after 7th (462+2>=464).
REQ-031 Bomb x=200,y=430, player_x=190, frame -> slot deactivates, player_hit one cycle high.
REQ-032 Three spawns separated by 32 frames (jitter off) -> slots 0,1,2 fill; fourth request: spawn_ready low until a slot retires.
REQ-033 shield_hit=3'b010 with slot1 overlapping player on same frame -> slot1 retires, player_hit stays 0.
REQ-034 clear asserted with spawn_valid and frame same cycle -> all inactive, cooldown 0, no spawn.
